// File: rtl/gshare_pht_ctrl_pkg.sv
// Shared types for the gshare PHT controller: counter encoding, FSM states
// and the 2-bit saturating counter update.
package gshare_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    LNT = 2'd1,
    LT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    TRD,
    TWR
  } fsm_e;

  function automatic ctr_t ctr_sat_update(input ctr_t c, input logic taken);
    ctr_t r;
    if (taken) r = (c == ST)  ? ST  : ctr_t'(c + 2'd1);
    else       r = (c == SNT) ? SNT : ctr_t'(c - 2'd1);
    return r;
  endfunction

endpackage

// File: rtl/gshare_pht_ctrl_if.sv
// Predict, train and SRAM-port signals of the gshare PHT controller.
// The controller uses the slave modport; its environment uses master.
interface gshare_pht_ctrl_if #(
  parameter int unsigned N = 7
);
  logic         pred_valid;
  logic         pred_ready;
  logic [N-1:0] pred_pc;
  logic         pred_resp_valid;
  logic         pred_taken;
  logic [N-1:0] pred_history;

  logic         train_valid;
  logic         train_ready;
  logic         train_taken;
  logic         train_mispredicted;
  logic [N-1:0] train_history;
  logic [N-1:0] train_pc;

  logic         mem_en;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [1:0]   mem_wdata;
  logic [1:0]   mem_rdata;

  modport slave (
    input  pred_valid, pred_pc,
    output pred_ready, pred_resp_valid, pred_taken, pred_history,
    input  train_valid, train_taken, train_mispredicted, train_history, train_pc,
    output train_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output pred_valid, pred_pc,
    input  pred_ready, pred_resp_valid, pred_taken, pred_history,
    output train_valid, train_taken, train_mispredicted, train_history, train_pc,
    input  train_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/gshare_pht_ctrl_fifo.sv
// Train request queue: DEPTH entries of {taken, history, pc}, head visible
// on rdata until popped. Push when full and pop when empty are ignored.
module gshare_train_fifo #(
  parameter  int unsigned N     = 7,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned W     = 2 * N + 1
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (count == DEPTH_C);
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    rdata   = store[rd_ptr];
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gshare_pht_ctrl.sv
// gshare PHT controller: power-up clear sweep, single SRAM port shared between
// predict lookups and queued train read-modify-writes, speculative history.
module gshare_pht_ctrl
  import gshare_pkg::*;
#(
  parameter int unsigned N        = 7,
  parameter int unsigned TQ_DEPTH = 4,
  parameter logic [1:0]  INIT_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             areset_n,
  gshare_pht_ctrl_if.slave bus,
  output logic             init_done
);

  localparam int unsigned QW      = 2 * N + 1;
  localparam int unsigned CW      = $clog2(TQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TQ_DEPTH);

  fsm_e          state;
  logic [N-1:0]  sweep_addr;
  logic [N-1:0]  history;
  logic [N-1:0]  hist_eff;
  logic [N-1:0]  pred_history_q;
  logic          resp_valid_q;
  logic          train_ready_q;
  logic [1:0]    rd_ctr;
  logic          resp_bit;

  logic          pred_ready_c;
  logic          pred_fire;
  logic          train_go;

  logic          q_push;
  logic          q_pop;
  logic [QW-1:0] q_wdata;
  logic [QW-1:0] q_rdata;
  logic          q_full;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic [CW-1:0] cnt_next;

  logic          head_taken;
  logic [N-1:0]  head_hist;
  logic [N-1:0]  head_pc;
  logic [N-1:0]  head_idx;

  logic          mem_en_c;
  logic          mem_we_c;
  logic [N-1:0]  mem_addr_c;
  logic [1:0]    mem_wdata_c;

  gshare_train_fifo #(
    .N     (N),
    .DEPTH (TQ_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .areset_n (areset_n),
    .push     (q_push),
    .pop      (q_pop),
    .wdata    (q_wdata),
    .rdata    (q_rdata),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  assign {head_taken, head_hist, head_pc} = q_rdata;

  always_comb begin
    resp_bit     = bus.mem_rdata[1];
    hist_eff     = resp_valid_q ? {history[N-2:0], resp_bit} : history;
    head_idx     = head_hist ^ head_pc;
    pred_ready_c = (state == IDLE) && !q_full;
    pred_fire    = bus.pred_valid && pred_ready_c;
    train_go     = (state == IDLE) && !pred_fire && !q_empty;
    q_push       = bus.train_valid && train_ready_q;
    q_pop        = (state == TWR);
    q_wdata      = {bus.train_taken, bus.train_history, bus.train_pc};
    cnt_next     = q_count + CW'(q_push) - CW'(q_pop);
  end

  // The SRAM port is decoded from state and same-cycle requests so a predict
  // can be issued in its accept cycle with the forwarded history.
  always_comb begin
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    unique case (state)
      INIT: begin
        mem_en_c    = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = sweep_addr;
        mem_wdata_c = INIT_CTR;
      end
      IDLE: begin
        if (pred_fire) begin
          mem_en_c   = 1'b1;
          mem_addr_c = hist_eff ^ bus.pred_pc;
        end else if (train_go) begin
          mem_en_c   = 1'b1;
          mem_addr_c = head_idx;
        end
      end
      TWR: begin
        mem_en_c    = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = head_idx;
        mem_wdata_c = ctr_sat_update(ctr_t'(rd_ctr), head_taken);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state          <= INIT;
      sweep_addr     <= '0;
      init_done      <= 1'b0;
      rd_ctr         <= '0;
      history        <= '0;
      resp_valid_q   <= 1'b0;
      pred_history_q <= '0;
      train_ready_q  <= 1'b0;
    end else begin
      train_ready_q <= (cnt_next != DEPTH_C);
      resp_valid_q  <= pred_fire;
      if (pred_fire) pred_history_q <= hist_eff;

      // A mispredict recovery wins over the response shift in the same cycle.
      if (q_push && bus.train_mispredicted)
        history <= {bus.train_history[N-2:0], bus.train_taken};
      else if (resp_valid_q)
        history <= {history[N-2:0], resp_bit};

      unique case (state)
        INIT: begin
          sweep_addr <= sweep_addr + 1'b1;
          if (sweep_addr == '1) begin
            state     <= IDLE;
            init_done <= 1'b1;
          end
        end
        IDLE: if (train_go) state <= TRD;
        TRD: begin
          rd_ctr <= bus.mem_rdata;
          state  <= TWR;
        end
        TWR:     state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

  assign bus.pred_ready      = pred_ready_c;
  assign bus.pred_resp_valid = resp_valid_q;
  assign bus.pred_taken      = resp_valid_q & resp_bit;
  assign bus.pred_history    = pred_history_q;
  assign bus.train_ready     = train_ready_q;
  assign bus.mem_en          = mem_en_c;
  assign bus.mem_we          = mem_we_c;
  assign bus.mem_addr        = mem_addr_c;
  assign bus.mem_wdata       = mem_wdata_c;

endmodule
